// File: rtl/soc_ctrl_boot_seq.sv
// soc_ctrl_boot_seq: OBI manager that programs soc_ctrl at boot
// and polls CORESTATUS until the core reports a non-zero status.
module soc_ctrl_boot_seq #(
  parameter logic [31:0] BaseAddr = 32'h0300_0000,
  parameter int unsigned PollGap  = 8,
  parameter int unsigned MaxPolls = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] boot_addr_i,
  input  logic [31:0] sram_dly_i,
  input  logic [31:0] boot_mode_i,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        timeout_o,
  output logic [31:0] core_status_o
);

  typedef enum logic [3:0] {
    IDLE,
    WR_BOOT,
    WR_DLY,
    WR_MODE,
    WR_FETCH,
    RD_STAT,
    GAP,
    DONE,
    ERROR
  } state_e;

  localparam logic PH_REQ = 1'b0;
  localparam logic PH_RSP = 1'b1;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [31:0] boot_q, boot_d;
  logic [31:0] dly_q, dly_d;
  logic [31:0] mode_q, mode_d;
  logic [31:0] poll_q, poll_d;
  logic [31:0] gap_q, gap_d;
  logic [31:0] stat_q, stat_d;
  logic        tmo_q, tmo_d;

  logic        acc;
  logic        acc_we;
  logic [31:0] acc_off;
  logic [31:0] acc_wdata;
  state_e      acc_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      phase_q <= PH_REQ;
      boot_q  <= '0;
      dly_q   <= '0;
      mode_q  <= '0;
      poll_q  <= '0;
      gap_q   <= '0;
      stat_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      boot_q  <= boot_d;
      dly_q   <= dly_d;
      mode_q  <= mode_d;
      poll_q  <= poll_d;
      gap_q   <= gap_d;
      stat_q  <= stat_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    boot_d      = boot_q;
    dly_d       = dly_q;
    mode_d      = mode_q;
    poll_d      = poll_q;
    gap_d       = gap_q;
    stat_d      = stat_q;
    tmo_d       = tmo_q;
    acc         = 1'b0;
    acc_we      = 1'b0;
    acc_off     = '0;
    acc_wdata   = '0;
    acc_nxt     = state_q;
    obi_req_o   = 1'b0;
    obi_addr_o  = '0;
    obi_we_o    = 1'b0;
    obi_be_o    = '0;
    obi_wdata_o = '0;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          boot_d  = boot_addr_i;
          dly_d   = sram_dly_i;
          mode_d  = boot_mode_i;
          poll_d  = '0;
          gap_d   = '0;
          tmo_d   = 1'b0;
          phase_d = PH_REQ;
          state_d = WR_BOOT;
        end
      end
      WR_BOOT: begin
        acc       = 1'b1;
        acc_we    = 1'b1;
        acc_off   = 32'h00;
        acc_wdata = boot_q;
        acc_nxt   = WR_DLY;
      end
      WR_DLY: begin
        acc       = 1'b1;
        acc_we    = 1'b1;
        acc_off   = 32'h10;
        acc_wdata = dly_q;
        acc_nxt   = WR_MODE;
      end
      WR_MODE: begin
        acc       = 1'b1;
        acc_we    = 1'b1;
        acc_off   = 32'h0c;
        acc_wdata = mode_q;
        acc_nxt   = WR_FETCH;
      end
      WR_FETCH: begin
        acc       = 1'b1;
        acc_we    = 1'b1;
        acc_off   = 32'h04;
        acc_wdata = 32'h1;
        acc_nxt   = RD_STAT;
      end
      RD_STAT: begin
        acc     = 1'b1;
        acc_off = 32'h08;
      end
      GAP: begin
        gap_d = gap_q + 32'd1;
        if (gap_d == PollGap) begin
          gap_d   = '0;
          phase_d = PH_REQ;
          state_d = RD_STAT;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared REQ/RSP handshake; rvalid is only honoured in RSP
    if (acc) begin
      if (phase_q == PH_REQ) begin
        obi_req_o   = 1'b1;
        obi_addr_o  = BaseAddr + acc_off;
        obi_we_o    = acc_we;
        obi_be_o    = 4'hF;
        obi_wdata_o = acc_wdata;
        if (obi_gnt_i) phase_d = PH_RSP;
      end else if (obi_rvalid_i) begin
        phase_d = PH_REQ;
        if (obi_err_i) begin
          tmo_d   = 1'b0;
          state_d = ERROR;
        end else if (acc_we) begin
          state_d = acc_nxt;
        end else begin
          stat_d = obi_rdata_i;
          poll_d = poll_q + 32'd1;
          if (obi_rdata_i != '0) begin
            state_d = DONE;
          end else if (poll_d == MaxPolls) begin
            tmo_d   = 1'b1;
            state_d = ERROR;
          end else if (PollGap == 0) begin
            state_d = RD_STAT;
          end else begin
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
    end
  end

  assign busy_o        = !(state_q inside {IDLE, DONE, ERROR});
  assign done_o        = (state_q == DONE);
  assign error_o       = (state_q == ERROR);
  assign timeout_o     = tmo_q;
  assign core_status_o = stat_q;

endmodule

// File: tb/tb_soc_ctrl_boot_seq.sv
// tb_soc_ctrl_boot_seq: scoreboard bench with a randomised OBI
// responder for the soc_ctrl boot sequencer.
module tb_soc_ctrl_boot_seq;

  localparam logic [31:0] BASE = 32'h0300_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] boot_addr_i = '0;
  logic [31:0] sram_dly_i = '0;
  logic [31:0] boot_mode_i = '0;
  logic        obi_req_o;
  logic        obi_gnt_i = 1'b0;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i = 1'b0;
  logic [31:0] obi_rdata_i = '0;
  logic        obi_err_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        timeout_o;
  logic [31:0] core_status_o;

  soc_ctrl_boot_seq dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .boot_addr_i   (boot_addr_i),
    .sram_dly_i    (sram_dly_i),
    .boot_mode_i   (boot_mode_i),
    .obi_req_o     (obi_req_o),
    .obi_gnt_i     (obi_gnt_i),
    .obi_addr_o    (obi_addr_o),
    .obi_we_o      (obi_we_o),
    .obi_be_o      (obi_be_o),
    .obi_wdata_o   (obi_wdata_o),
    .obi_rvalid_i  (obi_rvalid_i),
    .obi_rdata_i   (obi_rdata_i),
    .obi_err_i     (obi_err_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .timeout_o     (timeout_o),
    .core_status_o (core_status_o)
  );

  always #5 clk_i = ~clk_i;

  txn_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          total = 0;
  int          bad = 0;
  int          max_dly = 0;
  int          gnt_dly = 0;
  int          rsp_dly = 0;
  int          err_idx = -1;
  int          acc_idx = 0;
  int          gap_cnt = 0;
  int          rd_cnt = 0;
  bit          pend = 0;
  bit          pend_rd = 0;
  bit          seen_wait = 0;
  bit          block = 0;
  logic [31:0] w_addr = '0;
  logic [31:0] w_wdata = '0;
  logic        w_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] ba, input logic [31:0] sd,
                          input logic [31:0] bm, input int nwr,
                          input int nrd);
    txn_t w[4];
    w[0] = '{BASE + 32'h00, 1'b1, ba};
    w[1] = '{BASE + 32'h10, 1'b1, sd};
    w[2] = '{BASE + 32'h0c, 1'b1, bm};
    w[3] = '{BASE + 32'h04, 1'b1, 32'h1};
    for (int i = 0; i < nwr; i++) exp_q.push_back(w[i]);
    for (int i = 0; i < nrd; i++)
      exp_q.push_back('{BASE + 32'h08, 1'b0, 32'h0});
  endtask

  // OBI responder: decides gnt/rvalid at negedge for the next posedge
  initial begin
    txn_t e;
    forever begin
      @(negedge clk_i);
      obi_gnt_i    = 1'b0;
      obi_rvalid_i = 1'b0;
      obi_err_i    = 1'b0;
      obi_rdata_i  = '0;
      if (!rst_ni) begin
        pend      = 0;
        seen_wait = 0;
      end else begin
        if (!obi_req_o) gap_cnt++;
        if (obi_req_o) begin
          check("outstanding", 32'(pend), 32'd0);
          check("be", 32'(obi_be_o), 32'hF);
        end
        if (seen_wait && obi_req_o) begin
          check("stable_addr", obi_addr_o, w_addr);
          check("stable_we", 32'(obi_we_o), 32'(w_we));
          check("stable_wdata", obi_wdata_o, w_wdata);
        end
        seen_wait = 0;
        if (pend) begin
          if (rsp_dly > 0) begin
            rsp_dly--;
          end else begin
            obi_rvalid_i = 1'b1;
            obi_err_i    = (acc_idx == err_idx);
            if (pend_rd && rd_q.size() > 0) obi_rdata_i = rd_q.pop_front();
            pend = 0;
            acc_idx++;
          end
        end else if (obi_req_o) begin
          if (gnt_dly > 0 || (block && obi_addr_o == BASE + 32'h04)) begin
            if (gnt_dly > 0) gnt_dly--;
            seen_wait = 1;
            w_addr    = obi_addr_o;
            w_we      = obi_we_o;
            w_wdata   = obi_wdata_o;
          end else begin
            obi_gnt_i = 1'b1;
            if (exp_q.size() == 0) begin
              check("extra_access", obi_addr_o, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("addr", obi_addr_o, e.addr);
              check("we", 32'(obi_we_o), 32'(e.we));
              check("wdata", obi_wdata_o, e.wdata);
            end
            if (!obi_we_o) begin
              if (rd_cnt > 0) check("poll_gap", 32'(gap_cnt >= 8), 32'd1);
              rd_cnt++;
              gap_cnt = 0;
            end
            pend    = 1;
            pend_rd = !obi_we_o;
            rsp_dly = $urandom_range(max_dly, 0);
            gnt_dly = $urandom_range(max_dly, 0);
          end
        end
      end
    end
  end

  task automatic run(input int poke, output int n);
    @(negedge clk_i);
    acc_idx = 0;
    rd_cnt  = 0;
    gap_cnt = 0;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 1;
    check("start_busy", 32'(busy_o), 32'd1);
    check("start_clr", 32'({done_o, error_o, timeout_o}), 32'd0);
    while (!done_o && !error_o && n < 3000) begin
      @(negedge clk_i);
      n++;
      start_i = (n == poke);
      if (n == poke) begin
        boot_addr_i = ~boot_addr_i;
        sram_dly_i  = 32'hDEAD_BEEF;
        boot_mode_i = 32'h5A5A_5A5A;
      end
    end
    start_i = 1'b0;
    check("finished", 32'(n < 3000), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    repeat (3) @(negedge clk_i);
    check("rst_req", 32'(obi_req_o), 32'd0);
    check("rst_addr", obi_addr_o, 32'd0);
    check("rst_be", 32'(obi_be_o), 32'd0);
    check("rst_flags",
          32'({busy_o, done_o, error_o, timeout_o}), 32'd0);
    check("rst_status", core_status_o, 32'd0);
    rst_ni = 1'b1;

    // zero-wait, first poll succeeds
    boot_addr_i = 32'h1000_0080;
    sram_dly_i  = 32'h3;
    boot_mode_i = 32'h0;
    max_dly = 0;
    rd_q.push_back(32'h1);
    push_seq(32'h1000_0080, 32'h3, 32'h0, 4, 1);
    run(0, n);
    check("lat11", 32'(n), 32'd11);
    check("t1_done", 32'(done_o), 32'd1);
    check("t1_err", 32'(error_o), 32'd0);
    check("t1_stat", core_status_o, 32'h1);
    check("t1_left", 32'(exp_q.size()), 32'd0);

    // random delays; inputs changed and start poked mid-run
    max_dly = 5;
    boot_addr_i = 32'h2000_0040;
    sram_dly_i  = 32'h7;
    boot_mode_i = 32'h2;
    rd_q.push_back(32'h1);
    push_seq(32'h2000_0040, 32'h7, 32'h2, 4, 1);
    run(6, n);
    check("t2_done", 32'(done_o), 32'd1);
    check("t2_stat", core_status_o, 32'h1);
    check("t2_left", 32'(exp_q.size()), 32'd0);

    // three zero polls then ready
    max_dly = 0;
    boot_addr_i = 32'h0000_1000;
    sram_dly_i  = 32'h1;
    boot_mode_i = 32'h1;
    rd_q.push_back(32'h0);
    rd_q.push_back(32'h0);
    rd_q.push_back(32'h0);
    rd_q.push_back(32'h8000_0000);
    push_seq(32'h0000_1000, 32'h1, 32'h1, 4, 4);
    run(0, n);
    check("t3_done", 32'(done_o), 32'd1);
    check("t3_reads", 32'(rd_cnt), 32'd4);
    check("t3_stat", core_status_o, 32'h8000_0000);
    check("t3_left", 32'(exp_q.size()), 32'd0);

    // never ready: timeout after 16 reads
    push_seq(32'h0000_1000, 32'h1, 32'h1, 4, 16);
    run(0, n);
    check("t4_err", 32'(error_o), 32'd1);
    check("t4_tmo", 32'(timeout_o), 32'd1);
    check("t4_done", 32'(done_o), 32'd0);
    check("t4_reads", 32'(rd_cnt), 32'd16);
    check("t4_stat", core_status_o, 32'h0);

    // bus error on SRAM_DLY write
    err_idx = 1;
    boot_addr_i = 32'hFFFF_FFF0;
    sram_dly_i  = 32'h9;
    push_seq(32'hFFFF_FFF0, 32'h9, 32'h1, 2, 0);
    run(0, n);
    check("t5_err", 32'(error_o), 32'd1);
    check("t5_tmo", 32'(timeout_o), 32'd0);
    repeat (4) @(negedge clk_i);
    check("t5_quiet", 32'(obi_req_o), 32'd0);
    check("t5_left", 32'(exp_q.size()), 32'd0);
    err_idx = -1;
    rd_q.push_back(32'h5);
    push_seq(32'hFFFF_FFF0, 32'h9, 32'h1, 4, 1);
    run(0, n);
    check("t5b_done", 32'(done_o), 32'd1);
    check("t5b_flags", 32'({error_o, timeout_o}), 32'd0);
    check("t5b_stat", core_status_o, 32'h5);

    // reset while FETCHEN request is pending
    block = 1;
    push_seq(32'hFFFF_FFF0, 32'h9, 32'h1, 4, 0);
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    k = 0;
    while (!(obi_req_o && obi_addr_o == BASE + 32'h04) && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    check("t6_fetch", 32'(k < 200), 32'd1);
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_req", 32'(obi_req_o), 32'd0);
    check("t6_bus", obi_addr_o | obi_wdata_o, 32'd0);
    check("t6_we_be", 32'({obi_we_o, obi_be_o}), 32'd0);
    check("t6_flags",
          32'({busy_o, done_o, error_o, timeout_o}), 32'd0);
    check("t6_stat", core_status_o, 32'd0);
    exp_q.delete();
    block = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("t6_idle", 32'({obi_req_o, busy_o}), 32'd0);

    // full sequence again after reset
    rd_q.push_back(32'h3);
    push_seq(32'hFFFF_FFF0, 32'h9, 32'h1, 4, 1);
    run(0, n);
    check("t7_lat", 32'(n), 32'd11);
    check("t7_done", 32'(done_o), 32'd1);
    check("t7_stat", core_status_o, 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
